onehot_encoder_serializer: RTL and testbench
============================================

Name: onehot_encoder_serializer

Overview:
- Inverse-direction companion to the team's 3-to-8 one-hot decoder.
- Accepts an 8-bit request/one-hot vector, then emits the 3-bit index of every set bit, one index per handshake beat, lowest index first.
- Sits between bit-vector producers (status/request registers) and index-based consumers such as the decoder, a mux select or a register-file address.
- Registered, valid/ready on both sides.

Parameters:
- WIDTH, 8, input vector width (power of two, >=2).
- IDXW, 3, index width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- in  input  WIDTH  request vector.
- out_valid  output  1  index beat valid.
- out_ready  input  1  consumer accepts beat.
- out  output  IDXW  index of the current set bit.
- out_last  output  1  current beat is the final set bit of the vector.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, pending=0.
  - in_ready=1 after reset, out_valid=0, out=0, out_last=0.
  - Overrides any in-progress vector; remaining indices are discarded.
- State IDLE:
  - in_ready=1, out_valid=0.
  - Accept when in_valid && in_ready.
  - in!=0: pending<=in, go to SCAN.
  - in==0: vector consumed and dropped, no beats, stay IDLE.
- State SCAN:
  - in_ready=0, out_valid=1.
  - out = index of lowest set bit of pending.
  - out_last=1 iff pending has exactly one set bit.
  - out and out_last are combinational from the pending register only, with no path from in or out_ready.
  - On out_valid && out_ready: clear that bit in pending.
  - If out_last, go to IDLE; otherwise stay in SCAN with the next-lowest bit.
  - out_ready=0: out, out_last and pending hold stable (AXI-style, no retraction).
- Latency:
  - Accept at edge N gives out_valid=1 in the cycle after edge N.
  - Back-to-back beats, one per cycle when out_ready=1.
  - Vector with k set bits occupies k cycles in SCAN.
  - in_ready returns to 1 in the cycle after the last beat handshake.
  - Throughput per vector = k+1 cycles minimum; there is no overlap of final beat and next accept.
- In IDLE: out=0, out_last=0.
- Boundaries:
  - in=8'hFF gives 8 beats, indices 0..7, out_last on 7.
  - Single bit gives one beat with out_last=1.
  - in_valid while in SCAN is ignored; the producer must hold the vector.
  - X on in while in_valid=0 has no effect.

Optional Feature:
- Macro ENC_MSB_FIRST_EN.
- Defined:
  - SCAN selects the highest set bit of pending, so beats emit in descending index order.
  - out_last still marks the final remaining bit.
- Undefined (default): lowest-index-first as above.
- All other timing is identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> in_ready=1, out_valid=0, out=0, out_last=0.
- One-hot sweep: for i=0..7, in=1<<i accepted -> one beat out=i, out_last=1, then in_ready=1 on the following cycle. Round-trip through the decoder must reproduce in.
- Multi-bit with backpressure: in=8'b1010_0110, out_ready toggling 1,0,1,0... -> beats 1,2,5,7 in order. Values stay stable while out_ready=0; out_last only on 7. With ENC_MSB_FIRST_EN the order is 7,5,2,1 and out_last is on 1.
- Zero vector: in=8'h00 accepted -> no out_valid, in_ready stays 1. Then in=8'h80 -> single beat out=7.
- Reset mid-vector: in=8'hFF, reset asserted after the 3rd beat handshake -> next cycle out_valid=0, in_ready=1. A new in=8'h01 gives a single beat out=0.
- Ignore while busy: in=8'h03 accepted, then in_valid=1 with in=8'h80 held through SCAN -> beats 0,1, then 8'h80 accepted and out=7.

Source files
------------

// File: rtl/onehot_encoder_serializer.sv
// Serialises a request vector into one index beat per set bit, lowest first.
// Define ENC_MSB_FIRST_EN to emit the highest set bit first instead.
module onehot_encoder_serializer #(
   parameter int WIDTH = 8,
   parameter int IDXW  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out,
   output logic             out_last
);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] clr;
   logic [IDXW-1:0]  sel;

   // pending is zero whenever idle, so out and out_last read 0 there.
   always_comb begin
      sel = '0;
`ifdef ENC_MSB_FIRST_EN
      for (int i = 0; i < WIDTH; i++)
         if (pending[i]) sel = IDXW'(i);
`else
      for (int i = WIDTH - 1; i >= 0; i--)
         if (pending[i]) sel = IDXW'(i);
`endif
   end

   assign clr      = WIDTH'(1) << sel;
   assign out      = sel;
   assign out_last = (pending != '0) &&
                     ((pending & (pending - WIDTH'(1))) == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pending   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in != '0) begin
                  pending   <= in;
                  state     <= SCAN;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            SCAN: begin
               if (out_ready) begin
                  pending <= pending & ~clr;
                  if (out_last) begin
                     state     <= IDLE;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_onehot_encoder_serializer.sv
// Bench for onehot_encoder_serializer: queue-based reference model plus
// directed vectors with literal expectations.
module tb_onehot_encoder_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] out;
   logic       out_last;

   int total = 0;
   int bad   = 0;

   int  q[$];
   int  got[$];
   bit  model_ok = 1'b0;

   onehot_encoder_serializer #(.WIDTH(8), .IDXW(3)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in(in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out(out),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a vector becomes the list of its set-bit indices in order.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         q.delete();
         model_ok = 1'b1;
      end else if (q.size() != 0) begin
         if (out_ready) void'(q.pop_front());
      end else if (in_valid) begin
`ifdef ENC_MSB_FIRST_EN
         for (int i = 7; i >= 0; i--) if (in[i]) q.push_back(i);
`else
         for (int i = 0; i < 8; i++) if (in[i]) q.push_back(i);
`endif
      end
   end

   initial forever begin
      @(negedge clk);
      if (model_ok) begin
         chk("m_in_ready", int'(in_ready), int'(q.size() == 0));
         chk("m_out_valid", int'(out_valid), int'(q.size() != 0));
         chk("m_out", int'(out), (q.size() != 0) ? q[0] : 0);
         chk("m_out_last", int'(out_last), int'(q.size() == 1));
      end
   end

   task automatic send(input logic [7:0] v);
      bit ok = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in = v;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in = 8'($urandom);
   endtask

   task automatic collect(input bit toggle, input int stop_after);
      bit done = 1'b0;
      got.delete();
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            got.push_back(int'(out));
            if (out_last || got.size() == stop_after) done = 1'b1;
         end
         @(posedge clk); #1;
         if (toggle) out_ready = ~out_ready;
         if (done) break;
      end
      if (!done) chk("collect_timeout", 0, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      int exp_multi[4];
      logic [7:0] rt;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out", int'(out), 0);
      chk("rst_out_last", int'(out_last), 0);

      for (int i = 0; i < 8; i++) begin
         send(8'(1) << i);
         collect(1'b0, 0);
         chk("sweep_count", got.size(), 1);
         rt = 8'(1) << got[0];
         chk("sweep_roundtrip", int'(rt), int'(8'(1) << i));
         chk("sweep_idx", got[0], i);
         @(negedge clk);
         chk("sweep_ready_back", int'(in_ready), 1);
      end

`ifdef ENC_MSB_FIRST_EN
      exp_multi = '{7, 5, 2, 1};
`else
      exp_multi = '{1, 2, 5, 7};
`endif
      send(8'b1010_0110);
      collect(1'b1, 0);
      chk("multi_count", got.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("multi_beat", (i < got.size()) ? got[i] : -1, exp_multi[i]);

      send(8'h00);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("zero_no_valid", int'(out_valid), 0);
         chk("zero_ready", int'(in_ready), 1);
      end
      send(8'h80);
      collect(1'b0, 0);
      chk("msb_count", got.size(), 1);
      chk("msb_idx", got[0], 7);

      send(8'hFF);
      collect(1'b0, 3);
      chk("mid_beats", got.size(), 3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_ready", int'(in_ready), 1);
      send(8'h01);
      collect(1'b0, 0);
      chk("post_rst_count", got.size(), 1);
      chk("post_rst_idx", got[0], 0);

      @(posedge clk); #1;
      in_valid = 1'b1;
      in = 8'h03;
      @(negedge clk);
      chk("busy_accept", int'(in_ready), 1);
      @(posedge clk); #1;
      in = 8'h80;
      collect(1'b0, 0);
      chk("busy_count", got.size(), 2);
`ifdef ENC_MSB_FIRST_EN
      chk("busy_b0", got[0], 1);
      chk("busy_b1", got[1], 0);
`else
      chk("busy_b0", got[0], 0);
      chk("busy_b1", got[1], 1);
`endif
      @(negedge clk);
      chk("busy_ready_back", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      collect(1'b0, 0);
      chk("busy_next_count", got.size(), 1);
      chk("busy_next_idx", got[0], 7);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
